// File: rtl/dkong3_pkg.sv
// rtl/dkong3_pkg.sv - shared types and constants for the dkong3 object DMA slice
package dkong3_pkg;

  localparam int OBJ_RAM_AW          = 10;
  localparam int OBJ_DMA_LEN_DEFAULT = 384;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    WAIT,
    WRITE,
    REL
  } obj_dma_state_t;

endpackage

// File: rtl/dkong3_obj_dma_if.sv
// rtl/dkong3_obj_dma_if.sv - CPU bus arbitration, source read and object RAM write bundle
interface dkong3_obj_dma_if #(
  parameter int SRC_AW = 16
);
  import dkong3_pkg::*;

  logic                  I_BUSAKn;
  logic                  O_BUSRQn;
  logic [SRC_AW-1:0]     O_SRC_A;
  logic                  O_SRC_RD;
  logic [7:0]            I_SRC_D;
  logic [OBJ_RAM_AW-1:0] O_OBJ_DMA_A;
  logic [7:0]            O_OBJ_DMA_D;
  logic                  O_OBJ_DMA_CE;

  modport master (
    input  I_BUSAKn, I_SRC_D,
    output O_BUSRQn, O_SRC_A, O_SRC_RD, O_OBJ_DMA_A, O_OBJ_DMA_D, O_OBJ_DMA_CE
  );

  modport slave (
    output I_BUSAKn, I_SRC_D,
    input  O_BUSRQn, O_SRC_A, O_SRC_RD, O_OBJ_DMA_A, O_OBJ_DMA_D, O_OBJ_DMA_CE
  );

endinterface

// File: rtl/dkong3_obj_dma.sv
// rtl/dkong3_obj_dma.sv - sprite-list DMA: copies LEN bytes of CPU work RAM into object RAM
module dkong3_obj_dma
  import dkong3_pkg::*;
#(
  parameter int LEN    = OBJ_DMA_LEN_DEFAULT,
  parameter int SRC_AW = 16
) (
  input  logic                    I_CLK_24M,
  input  logic                    I_RESET,
  input  logic                    I_CE,
  input  logic                    I_START,
  input  logic [7:0]              I_SRC_PAGE,
  input  logic                    I_DST_BANK,
  dkong3_obj_dma_if.master        bus,
  output logic                    O_BUSY,
  output logic                    O_DONE
);

  localparam int                IDX_W = 11;
  localparam logic [IDX_W-1:0] LEN_L = IDX_W'(LEN);

  obj_dma_state_t   state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [7:0]       page_q, page_d;
  logic             bank_q, bank_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             src_rd, obj_ce;
  logic             bus_granted;

  assign bus_granted = ~bus.I_BUSAKn;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    page_d  = page_q;
    bank_d  = bank_q;
    data_d  = data_q;
    done_d  = 1'b0;
    src_rd  = 1'b0;
    obj_ce  = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_START) begin
          page_d  = I_SRC_PAGE;
          bank_d  = I_DST_BANK;
          index_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (I_CE && bus_granted) state_d = READ;
      end
      READ: begin
        // A withdrawn grant stalls here, so no read is issued without the bus.
        if (I_CE && bus_granted) begin
          src_rd  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (I_CE) begin
          data_d  = bus.I_SRC_D;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (I_CE) begin
          obj_ce  = 1'b1;
          index_d = index_q + 1'b1;
          state_d = (index_q + 1'b1 == LEN_L) ? REL : READ;
        end
      end
      REL: begin
        if (I_CE) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      state_q <= IDLE;
      index_q <= '0;
      page_q  <= '0;
      bank_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      page_q  <= page_d;
      bank_q  <= bank_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Addresses follow the index continuously; the strobes mark the cycle that counts.
  assign bus.O_SRC_A      = SRC_AW'({page_q, 8'h00}) + SRC_AW'(index_q);
  assign bus.O_OBJ_DMA_A  = {bank_q, 9'd0} + index_q[OBJ_RAM_AW-1:0];
  assign bus.O_OBJ_DMA_D  = data_q;
  assign bus.O_SRC_RD     = src_rd & ~I_RESET;
  assign bus.O_OBJ_DMA_CE = obj_ce & ~I_RESET;
  assign bus.O_BUSRQn     = (state_q == IDLE);
  assign O_BUSY           = (state_q != IDLE);
  assign O_DONE           = done_q;

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// tb/tb_dkong3_obj_dma.sv - randomized self-checking bench for dkong3_obj_dma
module tb_dkong3_obj_dma;
  import dkong3_pkg::*;

  localparam int LEN    = 384;
  localparam int SRC_AW = 16;
  localparam int BOUND  = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       start;
  logic [7:0] page;
  logic       bank;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  dkong3_obj_dma_if #(.SRC_AW(SRC_AW)) bus ();

  dkong3_obj_dma #(.LEN(LEN), .SRC_AW(SRC_AW)) dut (
    .I_CLK_24M (clk),
    .I_RESET   (rst),
    .I_CE      (ce),
    .I_START   (start),
    .I_SRC_PAGE(page),
    .I_DST_BANK(bank),
    .bus       (bus),
    .O_BUSY    (busy),
    .O_DONE    (done)
  );

  // Work RAM model: a read presents the addressed byte until the next read.
  logic [7:0]  src_mem [0:65535];
  logic [15:0] rd_addr = '0;
  always @(posedge clk) if (bus.O_SRC_RD) rd_addr <= bus.O_SRC_A;
  assign bus.I_SRC_D = src_mem[rd_addr];

  int checks = 0;
  int errors = 0;
  int grant_delay;
  int drop_at;

  logic [9:0]  wr_a_log [$];
  logic [7:0]  wr_d_log [$];
  logic [15:0] rd_a_log [$];
  int done_cnt, early_cnt, rd_noack_cnt, wr_in_xfer, drop_left, req_ce;
  int hold_ticks, last_hold;
  bit counting, seen_ack, busy_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: samples on negedge, drives I_CE and the bus arbiter after posedge.
  initial begin
    logic nxt;
    ce = 1'b0; bus.I_BUSAKn = 1'b1;
    done_cnt = 0; early_cnt = 0; rd_noack_cnt = 0; wr_in_xfer = 0;
    drop_left = 0; req_ce = 0; hold_ticks = 0; last_hold = 0;
    counting = 0; seen_ack = 0; busy_prev = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) begin seen_ack = 0; wr_in_xfer = 0; end
      if (!busy && busy_prev && counting) last_hold = hold_ticks;
      if (!busy) counting = 0;
      if (bus.O_SRC_RD) begin
        rd_a_log.push_back(bus.O_SRC_A);
        if (bus.I_BUSAKn) rd_noack_cnt++;
        if (!seen_ack) early_cnt++;
      end
      if (bus.O_OBJ_DMA_CE) begin
        wr_a_log.push_back(bus.O_OBJ_DMA_A);
        wr_d_log.push_back(bus.O_OBJ_DMA_D);
        wr_in_xfer++;
        if (!seen_ack) early_cnt++;
      end
      if (done) done_cnt++;
      if (ce && busy) begin
        if (counting) hold_ticks++;
        else if (!bus.O_BUSRQn && !bus.I_BUSAKn) begin
          counting = 1; seen_ack = 1; hold_ticks = 0;
        end
      end
      busy_prev = busy;
      nxt = bus.I_BUSAKn;
      if (bus.O_BUSRQn) begin
        req_ce = 0; drop_left = 0; nxt = 1'b1;
      end else begin
        if (drop_left > 0) begin
          if (ce) drop_left--;
          if (drop_left == 0) nxt = 1'b0;
        end else if (bus.I_BUSAKn) begin
          if (ce) req_ce++;
          if (req_ce >= grant_delay) nxt = 1'b0;
        end
        if (bus.O_OBJ_DMA_CE && drop_at != 0 && wr_in_xfer == drop_at) begin
          drop_left = 5; nxt = 1'b1;
        end
      end
      @(posedge clk); #1;
      bus.I_BUSAKn = nxt;
      ce = ce ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic run_xfer(input logic [7:0] pg, input logic bk, input int mid_at,
                          output int wbase, output int rbase);
    int  dbase, cyc;
    bit  mid_done;
    mid_done = 0;
    wbase = wr_a_log.size(); rbase = rd_a_log.size(); dbase = done_cnt;
    @(posedge clk); #1; page = pg; bank = bk; start = 1'b1;
    @(negedge clk); chk("busy_before_start", busy, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); chk("busy_after_start", busy, 1'b1);
    cyc = 0;
    while (done_cnt == dbase && cyc < BOUND) begin
      @(posedge clk); #1; start = 1'b0;
      if (mid_at >= 0 && !mid_done && wr_a_log.size() - wbase == mid_at) begin
        page = 8'h00; bank = ~bk; start = 1'b1; mid_done = 1;
      end
      cyc++;
      @(negedge clk);
    end
    @(posedge clk); #1; start = 1'b0;
    chk("xfer_timeout", cyc < BOUND, 1'b1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - dbase, 1);
    chk("busrq_released", bus.O_BUSRQn, 1'b1);
    chk("busy_cleared", busy, 1'b0);
  endtask

  // Reference: byte i of page pg lands at (bank*512 + i) mod 1024.
  task automatic check_logs(input logic [7:0] pg, input logic bk, input int wbase, input int rbase);
    logic [15:0] sa;
    logic [9:0]  da;
    chk("write_count", wr_a_log.size() - wbase, LEN);
    chk("read_count", rd_a_log.size() - rbase, LEN);
    if (wr_a_log.size() >= wbase + LEN && rd_a_log.size() >= rbase + LEN) begin
      for (int i = 0; i < LEN; i++) begin
        sa = 16'((int'(pg) * 256 + i) % 65536);
        da = 10'((int'(bk) * 512 + i) % 1024);
        chk("src_addr", rd_a_log[rbase + i], sa);
        chk("obj_addr", wr_a_log[wbase + i], da);
        chk("obj_data", wr_d_log[wbase + i], src_mem[sa]);
      end
    end
  endtask

  initial begin
    int wb, rb, cyc, wsnap, rsnap, dsnap, esnap, nsnap;
    rst = 1'b1; start = 1'b0; page = 8'h00; bank = 1'b0;
    grant_delay = 2; drop_at = 0;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busrq", bus.O_BUSRQn, 1'b1);
    chk("rst_src_rd", bus.O_SRC_RD, 1'b0);
    chk("rst_obj_ce", bus.O_OBJ_DMA_CE, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_src_a", bus.O_SRC_A, 16'h0000);
    chk("rst_obj_a", bus.O_OBJ_DMA_A, 10'h000);
    chk("rst_obj_d", bus.O_OBJ_DMA_D, 8'h00);

    run_xfer(8'h70, 1'b0, -1, wb, rb);
    check_logs(8'h70, 1'b0, wb, rb);
    chk("hold_ticks_grant2", last_hold, 3 * LEN + 1);

    run_xfer(8'h74, 1'b1, -1, wb, rb);
    check_logs(8'h74, 1'b1, wb, rb);
    chk("bank1_first_a", wr_a_log[wb], 10'h200);
    chk("bank1_last_a", wr_a_log[wb + LEN - 1], 10'h37F);
    chk("bank1_first_src", rd_a_log[rb], 16'h7400);
    chk("bank1_last_src", rd_a_log[rb + LEN - 1], 16'h757F);

    grant_delay = 20;
    esnap = early_cnt;
    run_xfer(8'h70, 1'b0, -1, wb, rb);
    check_logs(8'h70, 1'b0, wb, rb);
    chk("no_access_before_busak", early_cnt - esnap, 0);
    chk("hold_ticks_grant20", last_hold, 3 * LEN + 1);
    grant_delay = 2;

    drop_at = 101;
    nsnap = rd_noack_cnt;
    run_xfer(8'h70, 1'b0, -1, wb, rb);
    check_logs(8'h70, 1'b0, wb, rb);
    chk("no_read_without_busak", rd_noack_cnt - nsnap, 0);
    drop_at = 0;

    run_xfer(8'h70, 1'b0, 50, wb, rb);
    check_logs(8'h70, 1'b0, wb, rb);

    wb = wr_a_log.size(); dsnap = done_cnt;
    @(posedge clk); #1; page = 8'h70; bank = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (wr_a_log.size() - wb < 50 && cyc < BOUND) begin
      @(posedge clk); cyc++;
    end
    chk("reset_wait_timeout", cyc < BOUND, 1'b1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_busrq", bus.O_BUSRQn, 1'b1);
    chk("mid_reset_busy", busy, 1'b0);
    chk("writes_before_reset", wr_a_log.size() - wb, 50);
    wsnap = wr_a_log.size(); rsnap = rd_a_log.size();
    repeat (60) @(negedge clk);
    chk("no_writes_after_reset", wr_a_log.size() - wsnap, 0);
    chk("no_reads_after_reset", rd_a_log.size() - rsnap, 0);
    chk("no_done_on_reset", done_cnt - dsnap, 0);
    run_xfer(8'h70, 1'b0, -1, wb, rb);
    check_logs(8'h70, 1'b0, wb, rb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
